// File: rtl/dsp_pkg.sv
// Shared types and default sizes for the analysis-DSP producer side.
package dsp_pkg;

    localparam int FFT_DEF      = 8;
    localparam int FFT_ITER_DEF = 3;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT
    } feeder_state_t;

endpackage

// File: rtl/dsp_frame_feeder_if.sv
// Sample-stream and DSP handshake bundle; master = frame feeder, slave = source/DSP side.
interface dsp_frame_feeder_if #(
    parameter int FFT      = dsp_pkg::FFT_DEF,
    parameter int FFT_iter = dsp_pkg::FFT_ITER_DEF
) ();
    import dsp_pkg::*;

    logic                  i_sample_valid;
    sample_t               i_sample;
    logic                  o_sample_ready;
    sample_t               o_frame [FFT];
    logic                  o_start;
    logic                  i_analy_finish;
    logic [FFT_iter-2:0]   i_argmax;
    logic [FFT_iter-2:0]   o_result;
    logic                  o_result_valid;
    logic [15:0]           o_drop_cnt;

    modport master (
        input  i_sample_valid, i_sample, i_analy_finish, i_argmax,
        output o_sample_ready, o_frame, o_start, o_result, o_result_valid, o_drop_cnt
    );

    modport slave (
        output i_sample_valid, i_sample, i_analy_finish, i_argmax,
        input  o_sample_ready, o_frame, o_start, o_result, o_result_valid, o_drop_cnt
    );

endinterface

// File: rtl/frame_shreg.sv
// DEPTH-deep sample shift register: entry 0 oldest, DEPTH-1 newest; sync clear wins over shift.
module frame_shreg
    import dsp_pkg::*;
#(
    parameter int DEPTH = FFT_DEF
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    shift,
    input  sample_t din,
    output sample_t q [DEPTH]
);

    sample_t regs_q [DEPTH];
    sample_t regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) regs_d[k] = '0;
        end else if (shift) begin
            for (int k = 0; k < DEPTH - 1; k++) regs_d[k] = regs_q[k+1];
            regs_d[DEPTH-1] = din;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign q = regs_q;

endmodule

// File: rtl/dsp_frame_feeder.sv
// Assembles serial samples into FFT-sample frames, starts the DSP and latches its argmax.
module dsp_frame_feeder
    import dsp_pkg::*;
#(
    parameter int FFT      = FFT_DEF,
    parameter int FFT_iter = FFT_ITER_DEF,
    parameter int HOP      = FFT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    dsp_frame_feeder_if.master  bus
);

    localparam int CNT_W = $clog2(FFT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FFT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FFT - HOP);

    generate
        if (HOP < 1 || HOP > FFT) begin : g_bad_hop
            $error("dsp_frame_feeder: HOP must lie in 1..FFT");
        end
        if ((1 << FFT_iter) != FFT) begin : g_bad_iter
            $error("dsp_frame_feeder: FFT must equal 2**FFT_iter");
        end
    endgenerate

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    feeder_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic [FFT_iter-2:0] result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                ready;
    logic                accept;
    sample_t             frame [FFT];

    // Ready looks only at registers, so the source never sees a combinational loop.
    assign ready  = (cnt_q < CNT_FULL) && (state_q != S_START);
    assign accept = bus.i_sample_valid && ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + {{(CNT_W-1){1'b0}}, accept};
        result_d       = result_q;
        result_valid_d = 1'b0;
        drop_cnt_d     = (bus.i_sample_valid && !ready) ? sat_inc(drop_cnt_q) : drop_cnt_q;

        unique case (state_q)
            S_FILL: begin
                if (cnt_d == CNT_FULL) state_d = S_START;
            end
            S_START: begin
                cnt_d   = CNT_RELOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The DSP holds its own copy of the frame, so refilling overlaps the analysis.
                if (bus.i_analy_finish) begin
                    result_d       = bus.i_argmax;
                    result_valid_d = 1'b1;
                    state_d        = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        start_d = (state_d == S_START);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_FILL;
            cnt_q          <= '0;
            start_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            start_q        <= start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    frame_shreg #(
        .DEPTH (FFT)
    ) u_shreg (
        .clk   (i_clk),
        .clr   (i_rst),
        .shift (accept),
        .din   (bus.i_sample),
        .q     (frame)
    );

    assign bus.o_frame        = frame;
    assign bus.o_sample_ready = ready;
    assign bus.o_start        = start_q;
    assign bus.o_result       = result_q;
    assign bus.o_result_valid = result_valid_q;
    assign bus.o_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_dsp_frame_feeder.sv
// Bench for dsp_frame_feeder (HOP=4): directed scenarios plus random traffic against a window/queue model.
module tb_dsp_frame_feeder;
    import dsp_pkg::*;

    localparam int FFT      = 8;
    localparam int FFT_iter = 3;
    localparam int HOP      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_frame_feeder_if #(.FFT(FFT), .FFT_iter(FFT_iter)) bus ();

    dsp_frame_feeder #(
        .FFT      (FFT),
        .FFT_iter (FFT_iter),
        .HOP      (HOP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sliding window of the last FFT accepted samples, a sample count,
    // and two flags saying whether a frame is being presented or analysed.
    sample_t     m_win [$];
    int          m_cnt = 0;
    bit          m_presenting = 0;
    bit          m_busy = 0;
    bit          m_rv = 0;
    logic [1:0]  m_result = '0;
    int          m_drop = 0;

    function automatic bit m_ready();
        return (m_cnt < FFT) && !m_presenting;
    endfunction

    initial begin
        for (int k = 0; k < FFT; k++) m_win.push_back('0);
    end

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_win = {};
            for (int k = 0; k < FFT; k++) m_win.push_back('0);
            m_cnt = 0; m_presenting = 0; m_busy = 0; m_rv = 0; m_result = '0; m_drop = 0;
        end else begin
            acc = bus.i_sample_valid && m_ready();
            if (bus.i_sample_valid && !acc && m_drop < 65535) m_drop++;
            if (acc) begin
                m_win.push_back(bus.i_sample);
                void'(m_win.pop_front());
                m_cnt++;
            end
            m_rv = 0;
            if (m_presenting) begin
                m_presenting = 0;
                m_busy = 1;
                m_cnt = FFT - HOP;
            end else if (m_busy) begin
                if (bus.i_analy_finish) begin
                    m_result = bus.i_argmax;
                    m_rv = 1;
                    m_busy = 0;
                end
            end else if (m_cnt == FFT) begin
                m_presenting = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bus.o_sample_ready), 32'(m_ready()));
            chk("start", 32'(bus.o_start), 32'(m_presenting));
            chk("result", 32'(bus.o_result), 32'(m_result));
            chk("result_valid", 32'(bus.o_result_valid), 32'(m_rv));
            chk("drop_cnt", 32'(bus.o_drop_cnt), 32'(m_drop));
            for (int k = 0; k < FFT; k++)
                chk($sformatf("frame[%0d]", k), 32'(bus.o_frame[k]), 32'(m_win[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int first, input int n);
        for (int v = first; v < first + n; v++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_sample       = sample_t'(v);
            tick();
        end
        bus.i_sample_valid = 1'b0;
    endtask

    initial begin
        bus.i_sample_valid = 1'b0;
        bus.i_sample       = '0;
        bus.i_analy_finish = 1'b0;
        bus.i_argmax       = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_ready", 32'(bus.o_sample_ready), 32'd1);
        chk("rst_drop", 32'(bus.o_drop_cnt), 32'd0);

        // First frame: 1..8 back to back, start the cycle after the 8th.
        feed(1, 8);
        chk("t1_start", 32'(bus.o_start), 32'd1);
        chk("t1_ready", 32'(bus.o_sample_ready), 32'd0);
        for (int k = 0; k < FFT; k++)
            chk("t1_frame", 32'(bus.o_frame[k]), 32'(k + 1));

        // Hop of 4 new samples, then backpressure and drops.
        tick();
        feed(9, 4);
        chk("t2_ready_low", 32'(bus.o_sample_ready), 32'd0);
        bus.i_sample_valid = 1'b1;
        repeat (5) tick();
        bus.i_sample_valid = 1'b0;
        chk("t3_drop5", 32'(bus.o_drop_cnt), 32'd5);

        bus.i_analy_finish = 1'b1;
        bus.i_argmax       = 2'd2;
        tick();
        bus.i_analy_finish = 1'b0;
        chk("t2_rv", 32'(bus.o_result_valid), 32'd1);
        chk("t2_result", 32'(bus.o_result), 32'd2);
        tick();
        chk("t2_rv_once", 32'(bus.o_result_valid), 32'd0);
        chk("t2_start", 32'(bus.o_start), 32'd1);
        for (int k = 0; k < FFT; k++)
            chk("t2_frame", 32'(bus.o_frame[k]), 32'(k + 5));

        // Finish and accept in the same cycle.
        tick();
        bus.i_sample_valid = 1'b1;
        bus.i_sample       = 16'sd100;
        bus.i_analy_finish = 1'b1;
        bus.i_argmax       = 2'd3;
        tick();
        bus.i_sample_valid = 1'b0;
        bus.i_analy_finish = 1'b0;
        chk("t6_rv", 32'(bus.o_result_valid), 32'd1);
        chk("t6_result", 32'(bus.o_result), 32'd3);
        chk("t6_newest", 32'(bus.o_frame[7]), 32'd100);
        chk("t6_prev", 32'(bus.o_frame[6]), 32'd12);

        // Drop counter saturation.
        bus.i_sample_valid = 1'b1;
        repeat (70000) tick();
        bus.i_sample_valid = 1'b0;
        chk("t3_sat", 32'(bus.o_drop_cnt), 32'h0000FFFF);

        // Finish while filling is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_result", 32'(bus.o_result), 32'd0);
        chk("t4_rst_drop", 32'(bus.o_drop_cnt), 32'd0);
        bus.i_analy_finish = 1'b1;
        bus.i_argmax       = 2'd3;
        tick();
        bus.i_analy_finish = 1'b0;
        chk("t4_result", 32'(bus.o_result), 32'd0);
        chk("t4_rv", 32'(bus.o_result_valid), 32'd0);

        // Reset while waiting with cnt=6, then a stale finish.
        feed(20, 8);
        chk("t5_start", 32'(bus.o_start), 32'd1);
        tick();
        feed(40, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_start", 32'(bus.o_start), 32'd0);
        chk("t5_rst_ready", 32'(bus.o_sample_ready), 32'd1);
        chk("t5_rst_f0", 32'(bus.o_frame[0]), 32'd0);
        chk("t5_rst_f7", 32'(bus.o_frame[7]), 32'd0);
        bus.i_analy_finish = 1'b1;
        bus.i_argmax       = 2'd1;
        tick();
        bus.i_analy_finish = 1'b0;
        chk("t5_stale_rv", 32'(bus.o_result_valid), 32'd0);
        chk("t5_stale_result", 32'(bus.o_result), 32'd0);
        feed(50, 7);
        chk("t5_no_start", 32'(bus.o_start), 32'd0);
        feed(57, 1);
        chk("t5_start8", 32'(bus.o_start), 32'd1);
        chk("t5_f0", 32'(bus.o_frame[0]), 32'd50);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 299) == 0);
            bus.i_sample_valid = ($urandom_range(0, 3) != 0);
            bus.i_sample       = sample_t'($urandom);
            bus.i_analy_finish = ($urandom_range(0, 5) == 0);
            bus.i_argmax       = 2'($urandom_range(0, 3));
            tick();
        end
        rst                = 1'b0;
        bus.i_sample_valid = 1'b0;
        bus.i_analy_finish = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_frame_feeder.md
Name: dsp_frame_feeder

Overview:
Producer side of the analysis DSP handshake. It accepts a serial stream of signed 16-bit audio samples and assembles them into a time-ordered frame of FFT samples. When a frame is complete it presents the frame and pulses start, then waits for the DSP's finish and latches the returned argmax bin. It supports overlapping frames (hop < FFT) and applies backpressure to the sample source while the DSP is busy.

Parameters:
FFT, 8, frame length in samples (power of two)
FFT_iter, 3, log2(FFT); result width is FFT_iter-1
HOP, 8, new samples per frame after the first; legal range 1..FFT; HOP<FFT retains FFT-HOP old samples

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active high
i_sample_valid  in  1  sample source has a sample
i_sample  in  16 signed  sample value
o_sample_ready  out  1  sample accepted this cycle when valid&ready
o_frame  out  FFT x 16 signed  frame to DSP; index 0 = oldest, FFT-1 = newest
o_start  out  1  one-cycle start pulse to DSP
i_analy_finish  in  1  DSP finished the frame
i_argmax  in  FFT_iter-1  DSP peak-bin index
o_result  out  FFT_iter-1  last latched argmax
o_result_valid  out  1  one-cycle pulse when o_result updates
o_drop_cnt  out  16  saturating count of samples offered while not ready

Behaviour:
- Reset (sync, i_rst=1 at posedge): state S_FILL, cnt=0, every o_frame entry 0, o_start=0, o_result=0, o_result_valid=0, o_drop_cnt=0. Reset overrides all other events in the same cycle.
- cnt is the number of valid samples in the frame, range 0..FFT.
- accept = i_sample_valid & o_sample_ready. On accept: the shift register moves each entry k to k-1, i_sample enters at FFT-1, and cnt increments.
- o_sample_ready = (cnt<FFT) & (state!=S_START). It is combinational from registers only.
- i_sample_valid & !o_sample_ready: the sample is dropped and o_drop_cnt increments, saturating at 0xFFFF.
- S_FILL:
  - If the next value of cnt equals FFT, go to S_START.
  - Entering S_FILL with cnt==FFT already true also goes to S_START on the next edge.
- S_START (exactly one cycle):
  - o_start=1, registered, high for the whole cycle.
  - o_frame holds the complete frame and does not shift this cycle.
  - Next edge: cnt <= FFT-HOP, go to S_WAIT.
- S_WAIT:
  - Samples are accepted while cnt<FFT, which gives backpressure once HOP new samples are collected.
  - On i_analy_finish=1: o_result <= i_argmax, o_result_valid=1 for the next cycle, go to S_FILL.
  - Finish and accept in the same cycle: both take effect.
- Latency:
  - Frame-completing sample accepted at cycle t → o_start high at t+1.
  - Finish sampled at t → o_result_valid high at t+1 → earliest next o_start at t+2.
  - The DSP latches o_frame on start, so shifting during S_WAIT is safe.
- i_analy_finish in S_FILL or S_START is ignored: no latch, no pulse.
- After a reset taken in S_WAIT, a late finish from the DSP arrives in S_FILL and is ignored by the rule above.
- HOP outside 1..FFT is an elaboration error, implemented as a generate-time $error.

Decomposition:
- Shared package dsp_pkg:
  - sample_t (logic signed [15:0])
  - default FFT/FFT_iter constants
  - feeder_state_t enum {S_FILL, S_START, S_WAIT}
- One sub-module, frame_shreg: FFT-deep sample shift register with shift enable and sync clear, output as an unpacked array.
- The FSM, counters and result latch stay in dsp_frame_feeder.

Test Plan:
1. Defaults, reset, then samples 1..8 on consecutive cycles → o_start one cycle after sample 8; o_frame[0..7]=1..8; o_sample_ready=0 during S_START.
2. HOP=4: after test 1 start, feed 9..12 in S_WAIT → ready drops after 12; finish with i_argmax=2 → o_result=2, o_result_valid for one cycle; o_start next-next cycle with o_frame=5..12.
3. Hold valid high for 5 cycles while ready=0 in S_WAIT → o_drop_cnt=5. Force 70000 drops → o_drop_cnt stays 0xFFFF.
4. i_analy_finish=1, i_argmax=3 in S_FILL before any start → o_result stays 0, no o_result_valid.
5. i_rst in S_WAIT with cnt=6 → next cycle all outputs 0, cnt=0; 8 fresh samples are needed before o_start; the stale finish is ignored.
6. HOP=4: finish and an accepted sample in the same S_WAIT cycle → result latched and sample shifted in, cnt+1.
